is_uart_rx_fsm: RTL and testbench
=================================

// Module: is_uart_rx_fsm
// PURPOSE
//  UART receive path; pairs with the controller's TX FSM on the same line format.
//  Deserialises rxd_i: 1 start bit, DATA_W data bits LSB first, optional parity, STOP_BITS stop bits.
//  Oversamples at OVS x baud and takes a 3-sample majority vote at mid-bit.
//  Presents each frame in a holding register with a valid/read handshake, error flags and RTS-style flow control.
// PARAMETERS
//  OVS        16  rx_ce_i ticks per bit; even, >= 8
//  PAR_EN     1   1 = parity bit present after data
//  PAR_ODD    0   0 = even parity, 1 = odd parity
//  STOP_BITS  2   stop bits checked, 1 or 2
// PORTS
//  clk_i          in   1       clock
//  rst_i          in   1       reset, asynchronous, active-low
//  rx_ce_i        in   1       oversample enable, 1-cycle pulse at OVS x baud
//  rxd_i          in   1       serial line, asynchronous, idles high
//  rx_rd_i        in   1       consumer read strobe; clears rx_data_en_o
//  rx_data_o      out  DATA_W  received byte, stable while rx_data_en_o = 1
//  rx_data_en_o   out  1       holding register valid
//  rx_par_err_o   out  1       parity error of held frame
//  rx_frm_err_o   out  1       stop-bit error of held frame
//  rx_ovr_err_o   out  1       sticky overrun, cleared by rx_rd_i
//  rxct_r_o       out  1       0 = ready to receive, 1 = holding register full
// BEHAVIOUR
//  Reset values
//   - All outputs 0; state = RIDLE; counters 0.
//   - Sync FFs = 1; armed = 1.
//   - Reset asserted mid-frame aborts the frame; no partial data is delivered.
//  Input sync
//   - rxd_i passes through a 2-FF synchronizer to rxd_s.
//   - All decisions use rxd_s, evaluated only on rx_ce_i cycles.
//  Bit timing
//   - tick counter 0..OVS-1 within each bit.
//   - Samples taken at ticks OVS/2-1, OVS/2, OVS/2+1; bit value = majority of the 3.
//   - The decision is made at tick OVS/2+1.
//  States
//   - RIDLE: on rx_ce_i with rxd_s = 0 and armed -> RSTRB, tick = 1.
//     While rxd_s = 1, armed <= 1.
//   - RSTRB: at decision, majority 1 -> RIDLE (false start, nothing delivered).
//     At tick OVS-1 -> RDT, tick = 0, bit_cnt = 0.
//   - RDT: at decision, shift bit into MSB of shreg (LSB first on the line) and accumulate parity.
//     At tick OVS-1 with bit_cnt = DATA_W-1 -> RPARB if PAR_EN, else RSTB1; otherwise bit_cnt++.
//   - RPARB: at decision, par_err = (bit ^ data_xor ^ PAR_ODD). At tick OVS-1 -> RSTB1.
//   - RSTB1: at decision, a 0 sets frm_err.
//     If STOP_BITS = 1, complete the frame now and -> RIDLE; else at tick OVS-1 -> RSTB2.
//   - RSTB2: at decision, a 0 sets frm_err; complete the frame and -> RIDLE.
//   - Completing at mid-stop-bit lets the FSM catch a back-to-back start bit.
//  Completion, registered one cycle after the final stop decision
//   - If rx_data_en_o = 0, or rx_rd_i is high that cycle: load rx_data_o and both error flags, set rx_data_en_o.
//   - Otherwise: drop the new frame, keep the held data, set rx_ovr_err_o.
//   - A frame with frm_err = 1 is still delivered with the flag set.
//   - After frm_err, armed <= 0. A break (line held low) yields exactly one frame, then waits for rxd_s = 1.
//  Handshake
//   - rx_rd_i with rx_data_en_o = 1 clears rx_data_en_o and rx_ovr_err_o next cycle.
//   - rx_rd_i while invalid has no effect.
//   - rxct_r_o = rx_data_en_o, registered.
//  Latency
//   - Start falling edge to rx_data_en_o:
//     (1 + DATA_W + PAR_EN + STOP_BITS - 1)*OVS + OVS/2 + 2 rx_ce ticks, +2 clk for sync/register.
// STRUCTURE
//  Package is_pkg_uart_controller:
//   - add rx_state_t {RIDLE, RSTRB, RDT, RPARB, RSTB1, RSTB2}.
//   - DATA_W is reused from the package.
//  Sub-module is_uart_rx_sampler: 2-FF sync, tick counter, 3-sample majority.
//   - Outputs: bit_val, bit_stb (decision), bit_end (tick OVS-1).
//  The FSM, shift register, parity and holding register stay in is_uart_rx_fsm.
// TESTING (OVS = 16, rx_ce_i = 1 every clk, PAR_EN = 1, PAR_ODD = 0, STOP_BITS = 2)
//  1 Frame 0xA5, parity 0, stops 1,1 -> rx_data_o = 8'hA5, en = 1, par/frm/ovr = 0, rxct_r_o = 1 until rx_rd_i.
//  2 Frame 0x3C with parity bit 1 -> data 0x3C, rx_par_err_o = 1. Frame 0x01 with 2nd stop = 0 -> rx_frm_err_o = 1.
//  3 rxd low for 6 ticks, then high -> no rx_data_en_o, FSM back in RIDLE.
//    A 1-tick glitch inside a data bit is rejected by the majority vote.
//  4 Two frames 0x11, 0x22 back-to-back, no rx_rd_i -> rx_data_o stays 0x11, rx_ovr_err_o = 1.
//    Next rx_rd_i clears both. Same with rx_rd_i on the completion cycle -> 0x22 loaded, no overrun.
//  5 Line held low 30 bit times -> exactly one frame 0x00 with frm_err = 1.
//    No further frames until the line goes high, then a valid 0x55 is received.
//  6 rst_i low during bit 4 of a frame -> all outputs 0 immediately; the next clean frame 0x7E is received correctly.

Source files
------------

// File: rtl/is_pkg_uart_controller.sv
// is_pkg_uart_controller: shared UART controller constants and FSM state types.
package is_pkg_uart_controller;
   localparam int DATA_W = 8;
   typedef enum logic [2:0] {RIDLE, RSTRB, RDT, RPARB, RSTB1, RSTB2} rx_state_t;
endpackage

// File: rtl/is_uart_rx_sampler.sv
// is_uart_rx_sampler: line synchroniser, per-bit oversample tick counter and 3-sample mid-bit majority vote.
module is_uart_rx_sampler #(
   parameter int OVS = 16
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic i_ce,
   input  logic i_rxd,
   input  logic i_start,
   input  logic i_run,
   output logic o_rxd_s,
   output logic o_bit_val,
   output logic o_bit_stb,
   output logic o_bit_end
);
   localparam int TW = $clog2(OVS);
   logic [1:0]    r_sync;
   logic [TW-1:0] r_tick;
   logic          r_s0, r_s1;
   logic          w_tick_ce;
   assign o_rxd_s   = r_sync[1];
   assign w_tick_ce = i_ce & i_run;
   assign o_bit_val = (r_s0 & r_s1) | (r_s0 & o_rxd_s) | (r_s1 & o_rxd_s);
   assign o_bit_stb = w_tick_ce & (r_tick == TW'(OVS/2+1));
   assign o_bit_end = w_tick_ce & (r_tick == TW'(OVS-1));
   // The start-detect tick counts as tick 0, so the counter resumes at 1.
   always_ff @(posedge clk_i or negedge rst_i)
      if (!rst_i) begin
         r_sync <= '1;
         r_tick <= '0;
         r_s0   <= 1'b0;
         r_s1   <= 1'b0;
      end else begin
         r_sync <= {r_sync[0], i_rxd};
         if (i_start) r_tick <= TW'(1);
         else if (w_tick_ce) r_tick <= o_bit_end ? '0 : r_tick + 1'b1;
         if (w_tick_ce && r_tick == TW'(OVS/2-1)) r_s0 <= o_rxd_s;
         if (w_tick_ce && r_tick == TW'(OVS/2)) r_s1 <= o_rxd_s;
      end
endmodule

// File: rtl/is_uart_rx_fsm.sv
// is_uart_rx_fsm: UART receiver FSM with parity/stop checking, holding register,
// overrun detection and RTS-style flow control.
module is_uart_rx_fsm
   import is_pkg_uart_controller::*;
#(
   parameter int OVS       = 16,
   parameter int PAR_EN    = 1,
   parameter int PAR_ODD   = 0,
   parameter int STOP_BITS = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              rx_ce_i,
   input  logic              rxd_i,
   input  logic              rx_rd_i,
   output logic [DATA_W-1:0] rx_data_o,
   output logic              rx_data_en_o,
   output logic              rx_par_err_o,
   output logic              rx_frm_err_o,
   output logic              rx_ovr_err_o,
   output logic              rxct_r_o
);
   localparam int CW = $clog2(DATA_W);
   rx_state_t         r_state, w_state_nxt;
   logic [DATA_W-1:0] r_shreg;
   logic [CW-1:0]     r_bit_cnt;
   logic              r_par, r_par_err, r_frm_err, r_armed, r_done;
   logic              w_rxd_s, w_bit_val, w_bit_stb, w_bit_end;
   logic              w_start, w_done, w_load, w_en_nxt;

   is_uart_rx_sampler #(.OVS(OVS)) u_sampler (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .i_ce     (rx_ce_i),
      .i_rxd    (rxd_i),
      .i_start  (w_start),
      .i_run    (r_state != RIDLE),
      .o_rxd_s  (w_rxd_s),
      .o_bit_val(w_bit_val),
      .o_bit_stb(w_bit_stb),
      .o_bit_end(w_bit_end)
   );

   assign w_start = rx_ce_i & (r_state == RIDLE) & ~w_rxd_s & r_armed;
   assign w_done  = w_bit_stb & ((r_state == RSTB2) | ((r_state == RSTB1) & (STOP_BITS == 1)));

   always_ff @(posedge clk_i or negedge rst_i)
      if (!rst_i) r_state <= RIDLE;
      else r_state <= w_state_nxt;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         RIDLE:   if (w_start) w_state_nxt = RSTRB;
         RSTRB:   if (w_bit_stb && w_bit_val) w_state_nxt = RIDLE;
                  else if (w_bit_end) w_state_nxt = RDT;
         RDT:     if (w_bit_end && r_bit_cnt == CW'(DATA_W-1)) w_state_nxt = (PAR_EN != 0) ? RPARB : RSTB1;
         RPARB:   if (w_bit_end) w_state_nxt = RSTB1;
         RSTB1:   if (w_done) w_state_nxt = RIDLE;
                  else if (w_bit_end) w_state_nxt = RSTB2;
         RSTB2:   if (w_done) w_state_nxt = RIDLE;
         default: w_state_nxt = RIDLE;
      endcase
   end

   // Disarm at the final stop decision so a break cannot retrigger before the line returns high.
   always_ff @(posedge clk_i or negedge rst_i)
      if (!rst_i) begin
         r_shreg   <= '0;
         r_bit_cnt <= '0;
         r_par     <= 1'b0;
         r_par_err <= 1'b0;
         r_frm_err <= 1'b0;
         r_armed   <= 1'b1;
         r_done    <= 1'b0;
      end else begin
         r_done <= w_done;
         if (w_start) begin
            r_par     <= 1'b0;
            r_par_err <= 1'b0;
            r_frm_err <= 1'b0;
         end
         if (w_bit_stb && r_state == RDT) begin
            r_shreg <= {w_bit_val, r_shreg[DATA_W-1:1]};
            r_par   <= r_par ^ w_bit_val;
         end
         if (w_bit_stb && r_state == RPARB) r_par_err <= w_bit_val ^ r_par ^ 1'(PAR_ODD);
         if (w_bit_stb && (r_state == RSTB1 || r_state == RSTB2) && !w_bit_val) r_frm_err <= 1'b1;
         if (w_bit_end && r_state == RSTRB) r_bit_cnt <= '0;
         else if (w_bit_end && r_state == RDT) r_bit_cnt <= r_bit_cnt + 1'b1;
         if (w_done && (r_frm_err || !w_bit_val)) r_armed <= 1'b0;
         else if (r_state == RIDLE && w_rxd_s) r_armed <= 1'b1;
      end

   assign w_load   = r_done & (~rx_data_en_o | rx_rd_i);
   assign w_en_nxt = w_load | (rx_data_en_o & ~rx_rd_i);

   always_ff @(posedge clk_i or negedge rst_i)
      if (!rst_i) begin
         rx_data_o    <= '0;
         rx_data_en_o <= 1'b0;
         rx_par_err_o <= 1'b0;
         rx_frm_err_o <= 1'b0;
         rx_ovr_err_o <= 1'b0;
         rxct_r_o     <= 1'b0;
      end else begin
         rx_data_en_o <= w_en_nxt;
         rxct_r_o     <= w_en_nxt;
         rx_ovr_err_o <= (r_done & ~w_load) | (rx_ovr_err_o & ~(rx_rd_i & rx_data_en_o));
         if (w_load) begin
            rx_data_o    <= r_shreg;
            rx_par_err_o <= r_par_err;
            rx_frm_err_o <= r_frm_err;
         end
      end
endmodule

// File: tb/tb_is_uart_rx_fsm.sv
// tb_is_uart_rx_fsm: scoreboard bench for the UART receiver at OVS=16, even parity, two stop bits.
`timescale 1ns/1ps
module tb_is_uart_rx_fsm;
   typedef struct packed {logic [7:0] d; logic pe; logic fe;} exp_t;
   logic       clk_i = 1'b0, rst_i = 1'b0, rx_ce_i = 1'b1, rxd_i = 1'b1, rx_rd_i = 1'b0;
   logic [7:0] rx_data_o;
   logic       rx_data_en_o, rx_par_err_o, rx_frm_err_o, rx_ovr_err_o, rxct_r_o;
   exp_t       sb[$];
   int         n_vec = 0, n_err = 0;

   always #5 clk_i = ~clk_i;

   is_uart_rx_fsm #(.OVS(16), .PAR_EN(1), .PAR_ODD(0), .STOP_BITS(2)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .rx_ce_i     (rx_ce_i),
      .rxd_i       (rxd_i),
      .rx_rd_i     (rx_rd_i),
      .rx_data_o   (rx_data_o),
      .rx_data_en_o(rx_data_en_o),
      .rx_par_err_o(rx_par_err_o),
      .rx_frm_err_o(rx_frm_err_o),
      .rx_ovr_err_o(rx_ovr_err_o),
      .rxct_r_o    (rxct_r_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
      n_vec++;
      if (obs !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, req);
      end
   endtask

   function automatic void push(input logic [7:0] d, input logic p, input logic s2);
      sb.push_back('{d: d, pe: p ^ (^d), fe: ~s2});
   endfunction

   task automatic idle(input int n);
      rxd_i = 1'b1;
      repeat (n) @(posedge clk_i);
   endtask

   // Drives one frame, one line bit per 16 clocks; optional glitch, read strobe or reset at clock k.
   task automatic send(input logic [7:0] d, input logic p, input logic s2,
                       input int glitch = -1, input int rd_at = -1, input int rst_at = -1);
      logic [11:0] b = {s2, 1'b1, p, d, 1'b0};
      exp_t e;
      for (int k = 0; k < 192; k++) begin
         @(posedge clk_i);
         #1;
         if (k == rst_at) begin
            rst_i = 1'b0;
            rxd_i = 1'b1;
            return;
         end
         rxd_i   = b[k/16] ^ (k == glitch);
         rx_rd_i = (k == rd_at);
         if (k == rd_at) begin
            e = sb.pop_front();
            chk("rd_data", rx_data_o, e.d);
         end
      end
      rx_rd_i = 1'b0;
   endtask

   task automatic pop_chk(input logic ovr);
      exp_t e = sb.pop_front();
      int   n = 0;
      @(negedge clk_i);
      while (!rx_data_en_o && n < 400) begin
         @(negedge clk_i);
         n++;
      end
      chk("en", rx_data_en_o, 1);
      chk("data", rx_data_o, e.d);
      chk("par_err", rx_par_err_o, e.pe);
      chk("frm_err", rx_frm_err_o, e.fe);
      chk("ovr", rx_ovr_err_o, ovr);
      chk("rxct_full", rxct_r_o, 1);
      @(posedge clk_i);
      #1 rx_rd_i = 1'b1;
      @(posedge clk_i);
      #1 rx_rd_i = 1'b0;
      @(negedge clk_i);
      chk("en_clr", rx_data_en_o, 0);
      chk("ovr_clr", rx_ovr_err_o, 0);
      chk("rxct_clr", rxct_r_o, 0);
   endtask

   initial begin
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      chk("rst_data", rx_data_o, 0);
      chk("rst_en", rx_data_en_o, 0);
      chk("rst_errs", {rx_par_err_o, rx_frm_err_o, rx_ovr_err_o}, 0);
      chk("rst_rxct", rxct_r_o, 0);
      @(posedge clk_i);
      #1 rst_i = 1'b1;
      idle(20);
      push(8'hA5, 1'b0, 1'b1); send(8'hA5, 1'b0, 1'b1); pop_chk(1'b0);
      push(8'h3C, 1'b1, 1'b1); send(8'h3C, 1'b1, 1'b1); pop_chk(1'b0);
      push(8'h01, 1'b1, 1'b0); send(8'h01, 1'b1, 1'b0); idle(20); pop_chk(1'b0);
      // short low pulse must be rejected as a false start
      for (int k = 0; k < 6; k++) begin
         @(posedge clk_i);
         #1 rxd_i = 1'b0;
      end
      idle(60);
      @(negedge clk_i);
      chk("false_start", rx_data_en_o, 0);
      push(8'h96, 1'b0, 1'b1); send(8'h96, 1'b0, 1'b1, 3*16+8); pop_chk(1'b0);
      // back-to-back without a read: second frame dropped, overrun flagged
      push(8'h11, 1'b0, 1'b1); send(8'h11, 1'b0, 1'b1); send(8'h22, 1'b0, 1'b1); pop_chk(1'b1);
      // read on the completion cycle accepts the new frame without overrun
      push(8'h11, 1'b0, 1'b1); send(8'h11, 1'b0, 1'b1);
      push(8'h22, 1'b0, 1'b1); send(8'h22, 1'b0, 1'b1, -1, 188); pop_chk(1'b0);
      // break: one frame with framing error, then silence until the line recovers
      push(8'h00, 1'b0, 1'b0);
      @(posedge clk_i);
      #1 rxd_i = 1'b0;
      repeat (250) @(posedge clk_i);
      pop_chk(1'b0);
      repeat (230) @(posedge clk_i);
      @(negedge clk_i);
      chk("break_once", rx_data_en_o, 0);
      idle(40);
      push(8'h55, 1'b0, 1'b1); send(8'h55, 1'b0, 1'b1); pop_chk(1'b0);
      // reset mid-frame clears the held frame and aborts the one in flight
      send(8'h33, 1'b0, 1'b1);
      @(negedge clk_i);
      chk("pre_rst_en", rx_data_en_o, 1);
      send(8'h7E, 1'b0, 1'b1, -1, -1, 5*16+8);
      #1;
      chk("arst_data", rx_data_o, 0);
      chk("arst_en", rx_data_en_o, 0);
      chk("arst_rxct", rxct_r_o, 0);
      repeat (3) @(posedge clk_i);
      #1 rst_i = 1'b1;
      idle(40);
      push(8'h7E, 1'b0, 1'b1); send(8'h7E, 1'b0, 1'b1); pop_chk(1'b0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
